// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the processor front end: sequencer states, opcodes, default widths.
package pkg_processador;

   localparam int unsigned ADDR_W_DEF  = 8;
   localparam int unsigned INSTR_W_DEF = 16;
   localparam int unsigned OPCODE_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } estado_t;

   localparam logic [OPCODE_W-1:0] OP_SOMA = 3'b000;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OPCODE_W-1:0] OP_DIV  = 3'b010;
   localparam logic [OPCODE_W-1:0] OP_MUL  = 3'b011;
   localparam logic [OPCODE_W-1:0] OP_CLR  = 3'b100;
   localparam logic [OPCODE_W-1:0] OP_STOP = 3'b101;
   localparam logic [OPCODE_W-1:0] OP_LER  = 3'b110;
   localparam logic [OPCODE_W-1:0] OP_ESC  = 3'b111;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory bus and decoder issue bus seen by the fetch sequencer.
interface busca_instrucao_if
   import pkg_processador::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
) ();

   // Instruction memory read channel
   logic                ImemReq;
   logic [ADDR_W-1:0]   ImemAddr;
   logic                ImemAck;
   logic [INSTR_W-1:0]  ImemData;

   // Issue channel towards decoder/datapath
   logic [INSTR_W-1:0]  Instr;
   logic [OPCODE_W-1:0] OpCode;
   logic                InstrValid;
   logic                ExecReady;
   logic                Stop;

   // Sequencer side
   modport master (
      output ImemReq, ImemAddr, Instr, OpCode, InstrValid,
      input  ImemAck, ImemData, ExecReady, Stop
   );

   // Memory / decoder side
   modport slave (
      input  ImemReq, ImemAddr, Instr, OpCode, InstrValid,
      output ImemAck, ImemData, ExecReady, Stop
   );

endinterface

// File: rtl/busca_instrucao_contador_timeout.sv
// Fetch timeout counter: counts enabled cycles, flags the TIMEOUT-th one.
module contador_timeout #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // The register holds cycles already elapsed, so the current cycle is the
   // TIMEOUT-th one when it equals TIMEOUT-1.
   localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   assign o_expired = i_enable && (r_count == LIMITE);

   // Elapsed-cycle counter, saturating at the limit
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMITE)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch sequencer: fetches words over req/ack, issues them under valid/ready.
module busca_instrucao
   import pkg_processador::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Start,
   busca_instrucao_if.master bus,
   output logic [ADDR_W-1:0] PC,
   output logic [15:0]       InstrCount,
   output logic              Halted,
   output logic              Fault
);

   estado_t             r_estado, w_estado_prox;
   logic [ADDR_W-1:0]   r_pc, w_pc_prox;
   logic [INSTR_W-1:0]  r_instr, w_instr_prox;
   logic [15:0]         r_count, w_count_prox;
   logic                r_req, r_valid;
   logic                r_halted, w_halted_prox;
   logic                r_fault, w_fault_prox;
   logic                w_aceite;
   logic                w_expirou;
   logic                w_to_clear, w_to_enable;

   assign w_aceite    = r_valid && bus.ExecReady;
   // Counter sits at zero outside FETCH, so every fetch starts a fresh budget
   assign w_to_clear  = (r_estado != FETCH);
   assign w_to_enable = (r_estado == FETCH) && !bus.ImemAck;

   contador_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .i_clear   (w_to_clear),
      .i_enable  (w_to_enable),
      .o_expired (w_expirou)
   );

   // Next-state and next-register values
   always_comb begin
      w_estado_prox = r_estado;
      w_pc_prox     = r_pc;
      w_instr_prox  = r_instr;
      w_count_prox  = r_count;
      w_halted_prox = r_halted;
      w_fault_prox  = r_fault;
      unique case (r_estado)
         IDLE: begin
            if (Start) begin
               w_pc_prox     = '0;
               w_estado_prox = FETCH;
            end
         end
         FETCH: begin
            // Ack takes priority over a simultaneous timeout
            if (bus.ImemAck) begin
               w_instr_prox  = bus.ImemData;
               w_estado_prox = ISSUE;
            end else if (w_expirou) begin
               w_fault_prox  = 1'b1;
               w_estado_prox = HALT;
            end
         end
         ISSUE: begin
            if (w_aceite) begin
               w_count_prox = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
               if (bus.Stop) begin
                  w_halted_prox = 1'b1;
                  w_estado_prox = HALT;
               end else begin
                  w_pc_prox     = r_pc + ADDR_W'(1);
                  w_estado_prox = FETCH;
               end
            end
         end
         HALT: begin
            if (Start) begin
               w_halted_prox = 1'b0;
               w_fault_prox  = 1'b0;
               w_pc_prox     = '0;
               w_count_prox  = '0;
               w_estado_prox = FETCH;
            end
         end
      endcase
   end

   // State and output registers; handshake flags follow the next state
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_estado <= IDLE;
         r_pc     <= '0;
         r_instr  <= '0;
         r_count  <= '0;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_estado <= w_estado_prox;
         r_pc     <= w_pc_prox;
         r_instr  <= w_instr_prox;
         r_count  <= w_count_prox;
         r_req    <= (w_estado_prox == FETCH);
         r_valid  <= (w_estado_prox == ISSUE);
         r_halted <= w_halted_prox;
         r_fault  <= w_fault_prox;
      end
   end

   assign bus.ImemReq    = r_req;
   assign bus.ImemAddr   = r_pc;
   assign bus.Instr      = r_instr;
   assign bus.OpCode     = r_instr[INSTR_W-1 -: OPCODE_W];
   assign bus.InstrValid = r_valid;
   assign PC             = r_pc;
   assign InstrCount     = r_count;
   assign Halted         = r_halted;
   assign Fault          = r_fault;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: random programs, memory/ready models, scoreboard monitor.
module tb_busca_instrucao;
   import pkg_processador::*;

   localparam int unsigned AW   = 3;
   localparam int unsigned IW   = 16;
   localparam int unsigned TO   = 15;
   localparam int unsigned MEMN = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
      logic [15:0]   cnt;
   } exp_t;

   logic          Clock = 1'b0;
   logic          Reset_n;
   logic          Start;
   logic [AW-1:0] PC;
   logic [15:0]   InstrCount;
   logic          Halted;
   logic          Fault;

   busca_instrucao_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   busca_instrucao #(
      .ADDR_W  (AW),
      .INSTR_W (IW),
      .TIMEOUT (TO)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .bus        (bus),
      .PC         (PC),
      .InstrCount (InstrCount),
      .Halted     (Halted),
      .Fault      (Fault)
   );

   always #5 Clock = ~Clock;

   // Decoder model: stop instruction recognised from the opcode alone
   assign bus.Stop = (bus.OpCode == OP_STOP);

   int n_vec  = 0;
   int n_miss = 0;

   logic [IW-1:0] mem [MEMN];
   int   acks_left  = 0;
   int   lat_min    = 0;
   int   lat_max    = 0;
   int   ready_mode = 0;
   bit   force_ack  = 1'b0;

   exp_t          exp_q [$];
   logic [AW-1:0] addr_q[$];
   bit            exp_halt, exp_fault;
   logic [AW-1:0] exp_pc;
   logic [15:0]   exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory model: answers each request after a random latency, while budget lasts
   initial begin
      int wait_cnt;
      int lat;
      wait_cnt = 0;
      lat      = 0;
      bus.ImemAck  = 1'b0;
      bus.ImemData = '0;
      forever begin
         @(posedge Clock);
         #1;
         bus.ImemAck = 1'b0;
         if (force_ack) begin
            bus.ImemAck  = 1'b1;
            bus.ImemData = 16'hA5A5;
         end else if (!bus.ImemReq) begin
            wait_cnt = 0;
            lat      = $urandom_range(lat_max, lat_min);
         end else if (acks_left > 0) begin
            if (wait_cnt >= lat) begin
               bus.ImemAck  = 1'b1;
               bus.ImemData = mem[bus.ImemAddr];
               acks_left--;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Datapath readiness: always, random, or five stall cycles per instruction
   initial begin
      int  low_left;
      bit  was_valid;
      low_left  = 0;
      was_valid = 1'b0;
      bus.ExecReady = 1'b1;
      forever begin
         @(posedge Clock);
         #1;
         case (ready_mode)
            0:       bus.ExecReady = 1'b1;
            1:       bus.ExecReady = ($urandom_range(0, 2) != 0);
            default: begin
               if (bus.InstrValid && !was_valid) low_left = 5;
               bus.ExecReady = (low_left == 0);
               if (low_left > 0) low_left--;
            end
         endcase
         was_valid = bus.InstrValid;
      end
   end

   // Monitor: compares fetch addresses and accepted instructions with the scoreboard
   initial begin
      bit            prev_req, prev_valid;
      logic [AW-1:0] held_addr, held_pc;
      logic [IW-1:0] held_instr;
      int            req_len, stall;
      exp_t          e;
      prev_req = 1'b0; prev_valid = 1'b0; req_len = 0; stall = 0;
      held_addr = '0; held_pc = '0; held_instr = '0;
      forever begin
         @(negedge Clock);
         if (!Reset_n) begin
            prev_req = 1'b0; prev_valid = 1'b0; req_len = 0; stall = 0;
         end else begin
            if (bus.ImemReq) begin
               if (!prev_req) begin
                  if (addr_q.size() == 0) begin
                     check("unexpected_fetch", 32'(bus.ImemAddr), 32'hFFFF_FFFF);
                     held_addr = bus.ImemAddr;
                  end else begin
                     held_addr = addr_q.pop_front();
                     check("fetch_addr", 32'(bus.ImemAddr), 32'(held_addr));
                  end
                  req_len = 0;
               end else begin
                  check("addr_stable", 32'(bus.ImemAddr), 32'(held_addr));
               end
               req_len++;
            end else if (prev_req && Fault) begin
               check("timeout_len", 32'(req_len), 32'(TO));
            end
            if (bus.InstrValid) begin
               if (prev_valid) begin
                  check("instr_stable", 32'(bus.Instr), 32'(held_instr));
                  check("pc_stable", 32'(PC), 32'(held_pc));
               end
               held_instr = bus.Instr;
               held_pc    = PC;
               if (bus.ExecReady) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_issue", 32'(bus.Instr), 32'hFFFF_FFFF);
                  end else begin
                     e = exp_q.pop_front();
                     check("instr", 32'(bus.Instr), 32'(e.instr));
                     check("opcode", 32'(bus.OpCode), 32'(e.instr[15:13]));
                     check("issue_pc", 32'(PC), 32'(e.pc));
                     check("issue_count", 32'(InstrCount), 32'(e.cnt));
                  end
                  if (ready_mode == 2) check("stall_len", 32'(stall), 32'd5);
                  stall = 0;
               end else begin
                  stall++;
               end
            end
            prev_valid = bus.InstrValid && !bus.ExecReady;
            prev_req   = bus.ImemReq;
         end
      end
   end

   // Program-order model: walk memory from 0 until a stop or the ack budget runs out
   task automatic build_model(input int budget);
      int   pc;
      int   k;
      exp_t e;
      pc = 0;
      k  = 0;
      exp_q.delete();
      addr_q.delete();
      forever begin
         addr_q.push_back(AW'(pc));
         if (k == budget) begin
            exp_fault = 1'b1; exp_halt = 1'b0; exp_pc = AW'(pc); exp_cnt = 16'(k);
            break;
         end
         e.pc    = AW'(pc);
         e.instr = mem[pc];
         e.cnt   = 16'(k);
         exp_q.push_back(e);
         k++;
         if (mem[pc][15:13] == OP_STOP) begin
            exp_fault = 1'b0; exp_halt = 1'b1; exp_pc = AW'(pc); exp_cnt = 16'(k);
            break;
         end
         pc = (pc + 1) % MEMN;
      end
   endtask

   function automatic logic [IW-1:0] word_nao_stop();
      logic [IW-1:0] w;
      w = 16'($urandom);
      if (w[15:13] == OP_STOP) w[15:13] = OP_CLR;
      return w;
   endfunction

   task automatic run_program(input int budget, input int rmode, input int lmin, input int lmax);
      int n;
      ready_mode = rmode;
      lat_min    = lmin;
      lat_max    = lmax;
      acks_left  = budget;
      build_model(budget);
      @(posedge Clock); #1 Start = 1'b1;
      @(posedge Clock); #1 Start = 1'b0;
      check("start_pc", 32'(PC), 32'd0);
      check("start_halted", 32'(Halted), 32'd0);
      check("start_fault", 32'(Fault), 32'd0);
      check("start_req", 32'(bus.ImemReq), 32'd1);
      n = 0;
      while (!(Halted || Fault) && n < 3000) begin
         @(negedge Clock);
         n++;
      end
      if (n >= 3000) check("run_bound", 32'(n), 32'd0);
      check("end_halted", 32'(Halted), 32'(exp_halt));
      check("end_fault", 32'(Fault), 32'(exp_fault));
      check("end_pc", 32'(PC), 32'(exp_pc));
      check("end_count", 32'(InstrCount), 32'(exp_cnt));
      repeat (3) @(negedge Clock);
      check("halt_req", 32'(bus.ImemReq), 32'd0);
      check("halt_valid", 32'(bus.InstrValid), 32'd0);
      check("left_issues", 32'(exp_q.size()), 32'd0);
      check("left_fetches", 32'(addr_q.size()), 32'd0);
   endtask

   task automatic reset_mid_fetch();
      int n;
      foreach (mem[i]) mem[i] = {OP_SOMA, 13'(i)};
      ready_mode = 0; lat_min = 3; lat_max = 3; acks_left = 50;
      build_model(50);
      @(posedge Clock); #1 Start = 1'b1;
      @(posedge Clock); #1 Start = 1'b0;
      n = 0;
      while (!(PC == 2 && bus.ImemReq) && n < 200) begin
         @(posedge Clock); #1;
         n++;
      end
      if (n >= 200) check("reset_wait_bound", 32'(n), 32'd0);
      #2 Reset_n = 1'b0;
      #1;
      check("rst_req", 32'(bus.ImemReq), 32'd0);
      check("rst_valid", 32'(bus.InstrValid), 32'd0);
      check("rst_pc", 32'(PC), 32'd0);
      check("rst_count", 32'(InstrCount), 32'd0);
      check("rst_instr", 32'(bus.Instr), 32'd0);
      check("rst_flags", 32'({Halted, Fault}), 32'd0);
      exp_q.delete();
      addr_q.delete();
      @(posedge Clock); #1 force_ack = 1'b1;
      @(posedge Clock); #2 Reset_n = 1'b1;
      @(posedge Clock); #1;
      @(posedge Clock); #1 force_ack = 1'b0;
      check("late_ack_req", 32'(bus.ImemReq), 32'd0);
      check("late_ack_valid", 32'(bus.InstrValid), 32'd0);
      check("late_ack_instr", 32'(bus.Instr), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      Reset_n = 1'b0;
      Start   = 1'b0;
      foreach (mem[i]) mem[i] = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_req", 32'(bus.ImemReq), 32'd0);
      check("reset_valid", 32'(bus.InstrValid), 32'd0);
      check("reset_pc", 32'(PC), 32'd0);
      check("reset_instr", 32'(bus.Instr), 32'd0);
      check("reset_count", 32'(InstrCount), 32'd0);
      check("reset_flags", 32'({Halted, Fault}), 32'd0);
      #2 Reset_n = 1'b1;

      // SOMA then STOP, ack two cycles after request
      foreach (mem[i]) mem[i] = word_nao_stop();
      mem[0] = 16'h0000;
      mem[1] = {OP_STOP, 13'h0011};
      run_program(10, 0, 2, 2);

      // SUB, DIV, STOP
      mem[0] = {OP_SUB, 13'h00A1};
      mem[1] = {OP_DIV, 13'h0B02};
      mem[2] = {OP_STOP, 13'h1FFF};
      run_program(10, 0, 1, 3);

      // Five stall cycles per instruction
      mem[0] = {OP_DIV, 13'h0123};
      mem[1] = {OP_MUL, 13'h0456};
      run_program(10, 2, 0, 2);

      // Memory never answers
      run_program(0, 0, 0, 0);

      // Ack on the last allowed cycle
      mem[0] = {OP_LER, 13'h0777};
      mem[1] = {OP_STOP, 13'h0000};
      run_program(10, 0, TO - 1, TO - 1);

      // Eight non-stop words: PC wraps, ninth fetch at 0 times out
      foreach (mem[i]) mem[i] = word_nao_stop();
      run_program(MEMN, 1, 0, 2);

      reset_mid_fetch();
      mem[0] = {OP_ESC, 13'h0042};
      mem[1] = {OP_STOP, 13'h0001};
      run_program(10, 0, 0, 1);

      for (int it = 0; it < 25; it++) begin
         foreach (mem[i]) mem[i] = 16'($urandom);
         run_program($urandom_range(1, 12), $urandom_range(0, 2), 0, $urandom_range(0, 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
